// File: rtl/bus_mem_slave.sv
// Word-addressable RAM target for the shared bus: decodes address phases,
// accepts single/burst writes and serves single/burst reads with ready/valid.
module bus_mem_slave #(
  parameter int         BUS_WIDTH  = 32,
  parameter int         CTRL_WIDTH = 8,
  parameter int         ADDR_WIDTH = 8,
  parameter logic [3:0] SLAVE_ID   = 4'h1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [BUS_WIDTH-1:0]  bus_in,
  input  logic [CTRL_WIDTH-1:0] ctrl_in,
  output logic [BUS_WIDTH-1:0]  bus_out,
  output logic [CTRL_WIDTH-1:0] ctrl_out
);

  typedef enum logic [2:0] {
    S_IDLE, S_ACK, S_WR, S_RD_FETCH, S_RD_DATA, S_DONE
  } state_t;

  state_t                r_state, w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_addr, w_addr_nxt;
  logic [2:0]            r_count, w_count_nxt;
  logic                  r_dir, w_dir_nxt;
  logic [BUS_WIDTH-1:0]  r_mem [2**ADDR_WIDTH];
  logic [BUS_WIDTH-1:0]  r_rdata;
  logic                  w_start, w_sel, w_wvalid, w_rready, w_we;
  logic                  w_unused;

  assign w_start  = ctrl_in[0];
  assign w_wvalid = ctrl_in[5];
  assign w_rready = ctrl_in[6];
  assign w_sel    = (bus_in[BUS_WIDTH-1 -: 4] == SLAVE_ID);
  assign w_unused = ^{bus_in[BUS_WIDTH-5:ADDR_WIDTH], ctrl_in[CTRL_WIDTH-1:7]};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_count <= '0;
      r_dir   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_addr  <= w_addr_nxt;
      r_count <= w_count_nxt;
      r_dir   <= w_dir_nxt;
    end
  end

  // RAM is never cleared; a write coinciding with reset is dropped so an aborted beat leaves no trace.
  always_ff @(posedge clk) begin
    if (w_we) r_mem[r_addr] <= bus_in;
    if (r_state == S_RD_FETCH) r_rdata <= r_mem[r_addr];
  end

  always_comb begin
    w_state_nxt = r_state;
    w_addr_nxt  = r_addr;
    w_count_nxt = r_count;
    w_dir_nxt   = r_dir;
    w_we        = 1'b0;
    bus_out     = '0;
    ctrl_out    = '0;
    case (r_state)
      S_IDLE: begin
        if (w_start && w_sel) begin
          w_addr_nxt  = bus_in[ADDR_WIDTH-1:0];
          w_dir_nxt   = ctrl_in[1];
          w_count_nxt = ctrl_in[4:2];
          w_state_nxt = S_ACK;
        end
      end
      S_ACK: begin
        ctrl_out[0] = 1'b1;
        w_state_nxt = r_dir ? S_WR : S_RD_FETCH;
      end
      S_WR: begin
        ctrl_out[6] = 1'b1;
        if (w_wvalid) begin
          w_we       = !rst;
          w_addr_nxt = r_addr + 1'b1;
          if (r_count == 3'd0) w_state_nxt = S_DONE;
          else                 w_count_nxt = r_count - 3'd1;
        end
      end
      S_RD_FETCH: begin
        w_state_nxt = S_RD_DATA;
      end
      S_RD_DATA: begin
        ctrl_out[5] = 1'b1;
        bus_out     = r_rdata;
        if (w_rready) begin
          w_addr_nxt = r_addr + 1'b1;
          if (r_count == 3'd0) begin
            w_state_nxt = S_DONE;
          end else begin
            w_count_nxt = r_count - 3'd1;
            w_state_nxt = S_RD_FETCH;
          end
        end
      end
      S_DONE: begin
        ctrl_out[7] = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_bus_mem_slave.sv
// Randomized bench for bus_mem_slave: drives bus transactions cycle by cycle and
// checks every output cycle against a word-array model of the RAM.
module tb_bus_mem_slave;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] bus_in = '0;
  logic [7:0]  ctrl_in = '0;
  logic [31:0] bus_out;
  logic [7:0]  ctrl_out;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] ref_mem [256];
  logic [31:0] wdata   [8];

  bus_mem_slave #(
    .BUS_WIDTH(32), .CTRL_WIDTH(8), .ADDR_WIDTH(8), .SLAVE_ID(4'h1)
  ) dut (
    .clk(clk), .rst(rst), .bus_in(bus_in), .ctrl_in(ctrl_in),
    .bus_out(bus_out), .ctrl_out(ctrl_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // rst_beat: 1-based beat at which reset is asserted together with the data (0 = none)
  task automatic do_write(input int addr, input int len, input int gap, input bit busy,
                          input int rst_beat);
    bus_in  = {4'h1, 20'($urandom), 8'(addr)};
    ctrl_in = {3'b000, 3'(len - 1), 1'b1, 1'b1};
    step();
    chk("wr_ack", 32'(ctrl_out), 32'h01);
    chk("wr_ack_bus", bus_out, 32'h0);
    ctrl_in = '0;
    bus_in  = $urandom;
    step();
    for (int b = 0; b < len; b++) begin
      for (int g = 0; g < gap; g++) begin
        chk("wr_stall", 32'(ctrl_out), 32'h40);
        chk("wr_stall_bus", bus_out, 32'h0);
        ctrl_in = busy ? 8'h03 : 8'h00;
        bus_in  = busy ? {4'h1, 20'h0, 8'($urandom)} : $urandom;
        step();
        ctrl_in = '0;
      end
      chk("wr_wready", 32'(ctrl_out), 32'h40);
      bus_in  = wdata[b];
      ctrl_in = 8'h20;
      if (rst_beat == b + 1) begin
        rst = 1'b1;
        step();
        rst     = 1'b0;
        ctrl_in = '0;
        chk("rst_mid_ctrl", 32'(ctrl_out), 32'h0);
        chk("rst_mid_bus", bus_out, 32'h0);
        step();
        chk("rst_mid_idle", 32'(ctrl_out), 32'h0);
        return;
      end
      ref_mem[(addr + b) % 256] = wdata[b];
      step();
    end
    ctrl_in = '0;
    chk("wr_done", 32'(ctrl_out), 32'h80);
    chk("wr_done_bus", bus_out, 32'h0);
    step();
    chk("wr_idle", 32'(ctrl_out), 32'h0);
  endtask

  task automatic do_read(input int addr, input int len, input int gap);
    logic [31:0] exp;
    bus_in  = {4'h1, 20'($urandom), 8'(addr)};
    ctrl_in = {3'b000, 3'(len - 1), 1'b0, 1'b1};
    step();
    chk("rd_ack", 32'(ctrl_out), 32'h01);
    ctrl_in = '0;
    bus_in  = $urandom;
    step();
    for (int b = 0; b < len; b++) begin
      chk("rd_fetch", 32'(ctrl_out), 32'h0);
      chk("rd_fetch_bus", bus_out, 32'h0);
      step();
      exp = ref_mem[(addr + b) % 256];
      for (int g = 0; g < gap; g++) begin
        chk("rd_hold", 32'(ctrl_out), 32'h20);
        chk("rd_hold_data", bus_out, exp);
        step();
      end
      chk("rd_rvalid", 32'(ctrl_out), 32'h20);
      chk("rd_data", bus_out, exp);
      ctrl_in = 8'h40;
      step();
      ctrl_in = '0;
    end
    chk("rd_done", 32'(ctrl_out), 32'h80);
    chk("rd_done_bus", bus_out, 32'h0);
    step();
    chk("rd_idle", 32'(ctrl_out), 32'h0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // reset with random inputs
    ctrl_in = $urandom;
    bus_in  = $urandom;
    step();
    chk("rst_ctrl0", 32'(ctrl_out), 32'h0);
    chk("rst_bus0", bus_out, 32'h0);
    ctrl_in = $urandom;
    bus_in  = {4'h1, 28'($urandom)};
    step();
    chk("rst_ctrl1", 32'(ctrl_out), 32'h0);
    chk("rst_bus1", bus_out, 32'h0);
    rst     = 1'b0;
    ctrl_in = '0;
    step();
    chk("rst_release_ctrl", 32'(ctrl_out), 32'h0);
    chk("rst_release_bus", bus_out, 32'h0);

    // fill the whole RAM so every later read has a known expectation
    for (int base = 0; base < 256; base += 8) begin
      for (int i = 0; i < 8; i++) wdata[i] = $urandom;
      do_write(base, 8, 0, 1'b0, 0);
    end

    // single write / read
    wdata[0] = 32'hDEADBEEF;
    do_write(5, 1, 0, 1'b0, 0);
    do_read(5, 1, 0);
    chk("single_model", ref_mem[5], 32'hDEADBEEF);

    // wrap-around burst
    for (int i = 0; i < 4; i++) wdata[i] = 32'(i + 1);
    do_write(8'hFE, 4, 0, 1'b0, 0);
    do_read(8'hFE, 4, 0);
    do_read(8'h00, 1, 0);
    do_read(8'h01, 1, 0);

    // stalls, with START reasserted during WR
    for (int i = 0; i < 8; i++) wdata[i] = $urandom;
    do_write(8'h40, 8, 2, 1'b1, 0);
    do_read(8'h40, 8, 3);

    // decode miss
    bus_in  = {4'h2, 28'h0000005};
    ctrl_in = 8'h03;
    step();
    chk("decode_miss_ctrl", 32'(ctrl_out), 32'h0);
    ctrl_in = '0;
    step();
    chk("decode_miss_idle", 32'(ctrl_out), 32'h0);
    do_read(5, 1, 0);

    // reset mid-burst at the 2nd beat
    for (int i = 0; i < 4; i++) wdata[i] = $urandom;
    do_write(8'h80, 4, 0, 1'b0, 0);
    for (int i = 0; i < 4; i++) wdata[i] = $urandom;
    do_write(8'h80, 4, 1, 1'b0, 2);
    do_read(8'h80, 1, 0);
    do_read(8'h82, 2, 0);

    // random traffic
    for (int it = 0; it < 40; it++) begin
      int a, l, g;
      a = $urandom_range(0, 255);
      l = $urandom_range(1, 8);
      g = $urandom_range(0, 2);
      if ($urandom_range(0, 1) == 1) begin
        for (int i = 0; i < 8; i++) wdata[i] = $urandom;
        do_write(a, l, g, 1'($urandom_range(0, 1)), 0);
      end else begin
        do_read(a, l, g);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bus_mem_slave.md
# bus_mem_slave

Word-addressable memory responder on the shared 32-bit bus, the target-side counterpart to the bus masters arbitrated by `BusController`. It decodes address phases from whichever master holds the bus, accepts single or burst writes into an internal RAM, and returns single or burst reads with a ready/valid handshake. Its `bus_out`/`ctrl_out` connect to a `BusController` slave input port; `bus_in`/`ctrl_in` connect to the controller's muxed outputs.

## Interface
- `BUS_WIDTH`, 32, data/address bus width
- `CTRL_WIDTH`, 8, control bus width
- `ADDR_WIDTH`, 8, RAM word-address width; depth = 2^ADDR_WIDTH words
- `SLAVE_ID`, 4'h1, value matched against `bus_in[31:28]` during the address phase

- `clk`  in  1  system clock; all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `bus_in`  in  BUS_WIDTH  muxed bus from controller: address or write data
- `ctrl_in`  in  CTRL_WIDTH  master control: [0] START, [1] WRITE (1=write, 0=read), [4:2] burst length minus 1, [5] WVALID, [6] RREADY; [1] and [4:2] meaningful only with START
- `bus_out`  out  BUS_WIDTH  read data
- `ctrl_out`  out  CTRL_WIDTH  slave control: [0] ACK, [5] RVALID, [6] WREADY, [7] DONE; [4:1] always 0

## Operation
- States: IDLE, ACK, WR, RD_FETCH, RD_DATA, DONE.
- IDLE: START=1 and `bus_in[31:28]==SLAVE_ID` -> latch addr=`bus_in[ADDR_WIDTH-1:0]`, dir=WRITE, count=`ctrl_in[4:2]`; go ACK. Otherwise remain IDLE.
- ACK: ACK=1 for exactly this cycle; -> WR if write, else RD_FETCH.
- WR: WREADY=1. Cycle with WVALID=1 is a beat: mem[addr]<=bus_in, addr<=addr+1. If count==0 on the beat -> DONE, else count--. WVALID=0 stalls indefinitely.
- RD_FETCH: synchronous RAM read of mem[addr]; -> RD_DATA.
- RD_DATA: RVALID=1, bus_out=fetched word, held stable until RREADY=1. Handshake: addr++; count==0 -> DONE, else count--, -> RD_FETCH.
- DONE: DONE=1 for one cycle; -> IDLE.
- Burst length 1..8 beats; addr increments modulo 2^ADDR_WIDTH (wraps, no error).
- START in any state other than IDLE is ignored; no queuing.
- bus_out is 0 in every state except RD_DATA; ctrl_out is 0 except the bits listed per state.
- `bus_in[27:ADDR_WIDTH]` ignored.

## Timing
- Reset: state=IDLE, bus_out=0, ctrl_out=0, addr=0, count=0. RAM contents not cleared. Reset asserted mid-burst aborts immediately; next cycle outputs 0; beats already written persist.
- START sampled at edge N -> ACK high during cycle N+1 -> WREADY (or RD_FETCH) from N+2.
- Write: 1 beat per cycle max; N-beat burst with WVALID held = START + ACK + N + DONE = N+3 cycles.
- Read: first RVALID at N+3; each beat minimum 2 cycles (fetch + data); N-beat burst with RREADY held = 2N+3 cycles including DONE.
- Write data to read-after-write same address: visible on next transaction's fetch.
- No combinational path from any input to any output.

## Test plan
- Reset: drive rst 2 cycles with random bus_in/ctrl_in -> bus_out=0, ctrl_out=0 throughout and one cycle after release.
- Single write/read: START write, addr 0x1000_0005, len 0, data 0xDEADBEEF -> ACK one cycle, DONE; then read same addr -> RVALID with bus_out=0xDEADBEEF, DONE, 2+3 cycle timing exact.
- Wrap burst: ADDR_WIDTH=8, write 4 beats at 0x1000_00FE data 1,2,3,4 -> read 4 beats at 0xFE returns 1,2,3,4; single read at 0x00 returns 3, at 0x01 returns 4.
- Stalls: write 8 beats with WVALID low 2 cycles between beats; read 8 with RREADY low 3 cycles per beat -> bus_out stable while RVALID&!RREADY, all 8 words correct, DONE only after 8th beat.
- Decode/busy: START with `bus_in[31:28]=4'h2` -> no ACK, stays IDLE; START reasserted during WR -> ignored, original burst completes with correct count.
- Reset mid-op: rst at 2nd beat of 4-beat write -> outputs 0 next cycle, IDLE; readback shows beat 1 written, beats 3-4 unchanged.
